uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CRYSTAL, default 22118400, input clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, line bit rate in bits/s.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 rx  input  1  serial line, idle high, asynchronous to clk.
REQ-006 dout_byte  output  8  last correctly framed received byte.
REQ-007 dout_rdy  output  1  one-clk pulse; dout_byte valid and updated this cycle.
REQ-008 frame_err  output  1  one-clk pulse; stop bit sampled low.
REQ-009 busy  output  1  high while a frame is in progress (state != IDLE).

Function
REQ-010 Line format SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
REQ-011 rx SHALL pass through a 2-flop synchronizer before any use; a third flop holds the previous synced value for edge detection.
REQ-012 Tick divisor DIV = CRYSTAL/(BAUD*16) - 1, integer division; the tick counter wraps at DIV, giving a one-clk tick every DIV+1 clocks.
REQ-013 The tick counter SHALL be cleared on the clock in which a start edge is accepted, so tick phase aligns to the start edge.
REQ-014 The counter SHALL be wide enough for DIV; DIV < 1 is illegal (elaboration error).
REQ-015 States: IDLE, START, DATA, STOP.
REQ-016 IDLE: synced rx falling edge (prev 1, now 0) -> START; sample count and bit count cleared.
REQ-017 Sample count (4 bits) increments on each tick; a bit's mid-point is the tick on which sample count = 7; the count wraps 15->0 at the end of each bit period.
REQ-018 START at mid-point: rx=0 -> DATA; rx=1 -> IDLE (glitch reject, no output pulse).
REQ-019 DATA at each mid-point: shift synced rx into bit 7 of the shift register (right shift); after the 8th bit -> STOP.
REQ-020 STOP at mid-point, rx=1: dout_byte <= shift register, dout_rdy pulses the following clk, -> IDLE.
REQ-021 STOP at mid-point, rx=0: frame_err pulses the following clk, dout_byte unchanged, -> IDLE with a break-wait flag set.
REQ-022 While the break-wait flag is set, no start is accepted until synced rx has been seen high for one clk; the flag then clears.
REQ-023 Returning to IDLE at mid-stop SHALL allow a back-to-back start edge arriving half a bit later to be accepted.
REQ-024 dout_rdy and frame_err SHALL never assert in the same cycle; each is high for exactly one clk per frame.
REQ-025 Latency: dout_rdy rises 1 clk after the mid-stop sampling tick.
REQ-026 No flow control: a new byte overwrites dout_byte regardless of whether the consumer has read it.

Reset
REQ-027 On reset: state IDLE, dout_byte 8'h00, dout_rdy 0, frame_err 0, busy 0, counters 0, synchronizer flops 1, break-wait flag 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no output pulse; after release, reception resumes only on a new falling edge.

Structure
REQ-029 A shared package uart_pkg SHALL hold the state encodings, the sample-count constants (mid = 7, last = 15, data bits = 8) and a function computing DIV from CRYSTAL/BAUD.
REQ-030 One sub-module uart_baud_tick (counter, sync clear input, tick output, DIV parameter) SHALL be instantiated; everything else lives in uart_rx.

Verification (bench params CRYSTAL=1600, BAUD=10 -> DIV=9, 160 clk/bit)
REQ-031 Send 8'hA5 correctly framed -> exactly one dout_rdy pulse, dout_byte=8'hA5, frame_err never high, busy low afterward.
REQ-032 Send 8'h00 then 8'hFF back-to-back with stop bits only (no idle gap) -> two dout_rdy pulses, values 8'h00 then 8'hFF.
REQ-033 Drive rx low for 40 clk, then high -> no pulse, state returns to IDLE, busy deasserts by clk 80 after the edge.
REQ-034 Send 8'h3C with stop bit forced 0 and hold rx low 500 clk -> one frame_err pulse, dout_byte keeps its previous value, no start accepted until rx goes high.
REQ-035 Assert reset at data bit 4 of 8'h55, release, then send 8'h81 -> no pulse for the aborted frame, dout_rdy with 8'h81.
REQ-036 Send 8'hC3 at BAUD +3% (155 clk/bit) -> dout_byte=8'hC3 with no frame_err.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver files.
// This file holds the FSM state encoding and the per-bit sample-count constants.
// It also provides a helper that computes the baud tick divisor.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  // The bit period is 16 ticks. Each bit is sampled on the tick where the count is 7.
  localparam logic [3:0] SAMPLE_MID  = 4'd7;
  localparam logic [3:0] SAMPLE_LAST = 4'd15;
  localparam int         DATA_BITS   = 8;

  // Returns the tick divisor for 16x oversampling. The tick counter wraps at this value.
  function automatic int calc_div(input int crystal, input int baud);
    return crystal / (baud * 16) - 1;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: a free-running divider that produces a 16x-baud sampling tick.
// Ports:
//   clk   - system clock
//   reset - asynchronous, active-high
//   clear - synchronous clear. It realigns the tick phase to the current clock.
//   tick  - one-clk pulse. It occurs every DIV+1 clocks, on the clock where the counter equals DIV.
module uart_baud_tick #(
  parameter int DIV = 9
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV < 1) ? 1 : $clog2(DIV + 1);
  localparam logic [CW-1:0] DIV_C     = CW'(DIV);
  localparam logic [CW-1:0] DIV_PRE_C = CW'(DIV - 1);

  generate
    if (DIV < 1) begin : g_div_illegal
      $error("uart_baud_tick: DIV must be at least 1");
    end
  endgenerate

  logic [CW-1:0] cnt_r;
  logic          tick_r;

  // The divider counter wraps at DIV. A clear forces it back to zero.
  // The tick is registered one count early, so it is high exactly while cnt_r equals DIV.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else if (clear) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else begin
      if (cnt_r == DIV_C) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end
      tick_r <= (cnt_r == DIV_PRE_C) && (DIV_C != DIV_PRE_C);
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: an 8N1 UART receiver that oversamples the line at 16x and samples each bit at mid-bit.
// Ports:
//   clk       - system clock
//   reset     - asynchronous, active-high
//   rx        - serial line. It idles high and is asynchronous to clk.
//   dout_byte - the last correctly framed byte
//   dout_rdy  - one-clk pulse when dout_byte is updated
//   frame_err - one-clk pulse when the stop bit is sampled low
//   busy      - high while a frame is in progress
module uart_rx #(
  parameter int CRYSTAL = 22118400,
  parameter int BAUD    = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] dout_byte,
  output logic       dout_rdy,
  output logic       frame_err,
  output logic       busy
);

  import uart_pkg::*;

  localparam int DIV = calc_div(CRYSTAL, BAUD);

  logic        sync1_r, sync2_r, prev_r;
  logic        rx_s, fall_s, tick_s, mid_s, start_s;

  uart_state_t state_r, state_next;
  logic [3:0]  sample_r, sample_next;
  logic [2:0]  bit_r, bit_next;
  logic [7:0]  shift_r, shift_next;
  logic [7:0]  byte_r, byte_next;
  logic        rdy_r, rdy_next;
  logic        ferr_r, ferr_next;
  logic        brk_r, brk_next;
  logic        busy_r, busy_next;

  // Two-flop synchronizer for rx. A third flop keeps the previous synced value for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      prev_r  <= 1'b1;
    end else begin
      sync1_r <= rx;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  assign rx_s   = sync2_r;
  assign fall_s = prev_r & ~sync2_r;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (start_s),
    .tick  (tick_s)
  );

  assign mid_s = tick_s && (sample_r == SAMPLE_MID);

  // Next-state and datapath logic for the receive FSM.
  always_comb begin
    state_next  = state_r;
    sample_next = sample_r;
    bit_next    = bit_r;
    shift_next  = shift_r;
    byte_next   = byte_r;
    rdy_next    = 1'b0;
    ferr_next   = 1'b0;
    brk_next    = brk_r;
    start_s     = 1'b0;

    if ((state_r != ST_IDLE) && tick_s) begin
      if (sample_r == SAMPLE_LAST) begin
        sample_next = 4'd0;
      end else begin
        sample_next = sample_r + 4'd1;
      end
    end else begin
      sample_next = sample_r;
    end

    case (state_r)
      ST_IDLE: begin
        // After a break, the line must be seen high once before a new start is accepted.
        if (brk_r) begin
          if (rx_s) begin
            brk_next = 1'b0;
          end else begin
            brk_next = 1'b1;
          end
        end else if (fall_s) begin
          start_s     = 1'b1;
          state_next  = ST_START;
          sample_next = 4'd0;
          bit_next    = 3'd0;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_START: begin
        if (mid_s) begin
          if (!rx_s) begin
            state_next = ST_DATA;
          end else begin
            state_next = ST_IDLE;  // the start was a glitch: drop it silently
          end
        end else begin
          state_next = ST_START;
        end
      end
      ST_DATA: begin
        if (mid_s) begin
          shift_next = {rx_s, shift_r[7:1]};
          bit_next   = bit_r + 3'd1;
          if (bit_r == 3'(DATA_BITS - 1)) begin
            state_next = ST_STOP;
          end else begin
            state_next = ST_DATA;
          end
        end else begin
          state_next = ST_DATA;
        end
      end
      ST_STOP: begin
        // Return to idle at mid-stop so that a back-to-back start edge is caught.
        if (mid_s) begin
          state_next = ST_IDLE;
          if (rx_s) begin
            byte_next = shift_r;
            rdy_next  = 1'b1;
          end else begin
            ferr_next = 1'b1;
            brk_next  = 1'b1;
          end
        end else begin
          state_next = ST_STOP;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    busy_next = (state_next != ST_IDLE);
  end

  // Register the FSM state, the counters and all outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      sample_r <= 4'd0;
      bit_r    <= 3'd0;
      shift_r  <= 8'h00;
      byte_r   <= 8'h00;
      rdy_r    <= 1'b0;
      ferr_r   <= 1'b0;
      brk_r    <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_next;
      sample_r <= sample_next;
      bit_r    <= bit_next;
      shift_r  <= shift_next;
      byte_r   <= byte_next;
      rdy_r    <= rdy_next;
      ferr_r   <= ferr_next;
      brk_r    <= brk_next;
      busy_r   <= busy_next;
    end
  end

  assign dout_byte = byte_r;
  assign dout_rdy  = rdy_r;
  assign frame_err = ferr_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: a directed self-checking bench for uart_rx.
// It runs at CRYSTAL=1600 and BAUD=10, which gives 160 clocks per bit.
module tb_uart_rx;

  localparam int CRYSTAL = 1600;
  localparam int BAUD    = 10;
  localparam int CPB     = 160;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] dout_byte;
  logic       dout_rdy;
  logic       frame_err;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;
  int rdy_cnt = 0;
  int ferr_cnt = 0;
  int both_cnt = 0;
  logic [7:0] got_q[$];

  uart_rx #(.CRYSTAL(CRYSTAL), .BAUD(BAUD)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .dout_byte (dout_byte),
    .dout_rdy  (dout_rdy),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Pulse monitor. Each pulse lasts one clk, so a cycle count is also a pulse count.
  always @(negedge clk) begin
    if (dout_rdy) begin
      rdy_cnt <= rdy_cnt + 1;
      got_q.push_back(dout_byte);
    end
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (dout_rdy && frame_err) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic val, input int n);
    rx = val;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stp, input int cpb);
    drive(1'b0, cpb);
    for (int i = 0; i < 8; i++) drive(b[i], cpb);
    drive(stp, cpb);
  endtask

  int r0, f0, q0;
  logic [7:0] b55;
  logic [31:0] v0, v1;

  initial begin
    rx    = 1'b1;
    reset = 1'b1;
    b55   = 8'h55;
    repeat (5) @(negedge clk);
    chk("rst_byte", 32'(dout_byte), 32'h00);
    chk("rst_rdy",  32'(dout_rdy),  32'h0);
    chk("rst_ferr", 32'(frame_err), 32'h0);
    chk("rst_busy", 32'(busy),      32'h0);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    // Single correct frame of A5
    r0 = rdy_cnt; f0 = ferr_cnt;
    send_frame(8'hA5, 1'b1, CPB);
    drive(1'b1, 2 * CPB);
    chk("a5_rdy_cnt",  32'(rdy_cnt - r0),  32'd1);
    chk("a5_byte",     32'(dout_byte),     32'hA5);
    chk("a5_ferr_cnt", 32'(ferr_cnt - f0), 32'd0);
    chk("a5_busy",     32'(busy),          32'h0);

    // Back-to-back 00 then FF, with no idle gap
    r0 = rdy_cnt; q0 = got_q.size();
    send_frame(8'h00, 1'b1, CPB);
    send_frame(8'hFF, 1'b1, CPB);
    drive(1'b1, 2 * CPB);
    chk("b2b_rdy_cnt", 32'(rdy_cnt - r0), 32'd2);
    v0 = (got_q.size() > q0)     ? 32'(got_q[q0])     : 32'hDEAD;
    v1 = (got_q.size() > q0 + 1) ? 32'(got_q[q0 + 1]) : 32'hDEAD;
    chk("b2b_first",  v0, 32'h00);
    chk("b2b_second", v1, 32'hFF);

    // Start-bit glitch of 40 clk
    r0 = rdy_cnt; f0 = ferr_cnt;
    drive(1'b0, 40);
    chk("glitch_busy_hi", 32'(busy), 32'h1);
    drive(1'b1, 50);
    chk("glitch_busy_lo",  32'(busy),          32'h0);
    drive(1'b1, 2 * CPB);
    chk("glitch_rdy_cnt",  32'(rdy_cnt - r0),  32'd0);
    chk("glitch_ferr_cnt", 32'(ferr_cnt - f0), 32'd0);

    // Framing error on 3C, followed by a break held for 500 clk
    r0 = rdy_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, CPB);
    drive(1'b0, 500);
    chk("brk_ferr_cnt", 32'(ferr_cnt - f0), 32'd1);
    chk("brk_rdy_cnt",  32'(rdy_cnt - r0),  32'd0);
    chk("brk_byte",     32'(dout_byte),     32'hFF);
    chk("brk_busy",     32'(busy),          32'h0);
    drive(1'b1, 2 * CPB);
    chk("brk_busy_after", 32'(busy), 32'h0);

    // Reset asserted in the middle of data bit 4 of 55
    r0 = rdy_cnt; f0 = ferr_cnt;
    drive(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive(b55[i], CPB);
    drive(b55[4], 80);
    reset = 1'b1;
    rx    = 1'b1;
    repeat (10) @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    drive(1'b1, 2 * CPB);
    chk("abort_rdy_cnt",  32'(rdy_cnt - r0),  32'd0);
    chk("abort_ferr_cnt", 32'(ferr_cnt - f0), 32'd0);
    chk("abort_byte",     32'(dout_byte),     32'h00);
    r0 = rdy_cnt;
    send_frame(8'h81, 1'b1, CPB);
    drive(1'b1, 2 * CPB);
    chk("after_rst_rdy_cnt", 32'(rdy_cnt - r0), 32'd1);
    chk("after_rst_byte",    32'(dout_byte),    32'h81);

    // C3 sent 3% fast, at 155 clk per bit
    r0 = rdy_cnt; f0 = ferr_cnt;
    send_frame(8'hC3, 1'b1, 155);
    drive(1'b1, 2 * CPB);
    chk("fast_rdy_cnt",  32'(rdy_cnt - r0),  32'd1);
    chk("fast_byte",     32'(dout_byte),     32'hC3);
    chk("fast_ferr_cnt", 32'(ferr_cnt - f0), 32'd0);

    chk("never_both", 32'(both_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
